// File: rtl/ip_rx.sv
// ip_rx: IPv4 receive parser; validates the 20-byte header of each frame and
// streams the payload of accepted packets with one cycle of latency.
module ip_rx #(
  parameter logic [31:0] P_LOCAL_IP = {8'd192, 8'd168, 8'd1, 8'd1}
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_local_ip,
  input  logic        i_local_ip_valid,
  input  logic [7:0]  i_mac_data,
  input  logic [15:0] i_mac_type,
  input  logic        i_mac_last,
  input  logic        i_mac_valid,
  output logic [7:0]  o_recv_data,
  output logic [7:0]  o_recv_type,
  output logic [15:0] o_recv_len,
  output logic [31:0] o_recv_src_ip,
  output logic        o_recv_last,
  output logic        o_recv_valid,
  output logic        o_drop
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} state_t;
  state_t      state;
  logic [15:0] cnt, total_len, cnt_n, pay_end, fold2;
  logic [31:0] local_ip, ip_copy, src_ip, sum, sum_n, dst_n;
  logic [23:0] dst_ip;
  logic [16:0] fold1;
  logic [7:0]  hi_byte, proto;
  logic        ver_ok, armed, accept;
  // Header checks use the last header byte straight off the bus so the decision lands at cnt 19.
  always_comb begin
    sum_n   = sum + {16'd0, hi_byte, i_mac_data};
    fold1   = {1'b0, sum_n[15:0]} + {1'b0, sum_n[31:16]};
    fold2   = fold1[15:0] + {15'd0, fold1[16]};
    dst_n   = {dst_ip, i_mac_data};
    cnt_n   = cnt == 16'hFFFF ? cnt : cnt + 16'd1;
    pay_end = total_len - 16'd1;
    accept  = ver_ok && fold2 == 16'hFFFF && (dst_n == ip_copy || dst_n == 32'hFFFFFFFF) &&
              (proto == 8'd1 || proto == 8'd17) && total_len >= 16'd21 && total_len <= 16'd1500;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      total_len     <= '0;
      local_ip      <= P_LOCAL_IP;
      ip_copy       <= '0;
      src_ip        <= '0;
      dst_ip        <= '0;
      sum           <= '0;
      hi_byte       <= '0;
      proto         <= '0;
      ver_ok        <= 1'b0;
      armed         <= 1'b0;
      o_recv_data   <= '0;
      o_recv_type   <= '0;
      o_recv_len    <= '0;
      o_recv_src_ip <= '0;
      o_recv_last   <= 1'b0;
      o_recv_valid  <= 1'b0;
      o_drop        <= 1'b0;
    end else begin
      o_recv_valid <= 1'b0;
      o_recv_last  <= 1'b0;
      o_drop       <= 1'b0;
      if (i_local_ip_valid) local_ip <= i_local_ip;
      // A frame already in flight when reset released is discarded until the bus has gone idle once.
      if (!i_mac_valid) armed <= 1'b1;
      if (i_mac_valid) begin
        cnt <= i_mac_last ? 16'd0 : cnt_n;
        case (state)
          IDLE: begin
            ip_copy <= local_ip;
            hi_byte <= i_mac_data;
            sum     <= '0;
            ver_ok  <= i_mac_data == 8'h45;
            state   <= armed && i_mac_type == 16'h0800 ? HDR : DISCARD;
            o_drop  <= i_mac_last && armed && i_mac_type == 16'h0800;
          end
          HDR: begin
            if (!cnt[0]) hi_byte <= i_mac_data;
            else sum <= sum_n;
            if (cnt == 16'd2) total_len[15:8] <= i_mac_data;
            if (cnt == 16'd3) total_len[7:0] <= i_mac_data;
            if (cnt == 16'd9) proto <= i_mac_data;
            if (cnt >= 16'd12 && cnt <= 16'd15) src_ip <= {src_ip[23:0], i_mac_data};
            if (cnt >= 16'd16) dst_ip <= {dst_ip[15:0], i_mac_data};
            if (i_mac_last) o_drop <= 1'b1;
            else if (cnt == 16'd19) begin
              if (accept) begin
                state         <= PAYLOAD;
                o_recv_type   <= proto;
                o_recv_len    <= total_len - 16'd20;
                o_recv_src_ip <= src_ip;
              end else begin
                state  <= DISCARD;
                o_drop <= 1'b1;
              end
            end
          end
          PAYLOAD: begin
            o_recv_data  <= i_mac_data;
            o_recv_valid <= 1'b1;
            o_recv_last  <= i_mac_last || cnt == pay_end;
            o_drop       <= i_mac_last && cnt != pay_end;
            if (cnt == pay_end) state <= DISCARD;
          end
          default: ;
        endcase
        if (i_mac_last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ip_rx.sv
// tb_ip_rx: directed and randomized frames for ip_rx, checked against a
// packet-level reference model (expected payload, drops, metadata, latency).
module tb_ip_rx;
  localparam logic [31:0] DEF_IP = {8'd192, 8'd168, 8'd1, 8'd1};
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] lip = '0;
  logic        lip_valid = 1'b0;
  logic [7:0]  mac_data = '0;
  logic [15:0] mac_type = '0;
  logic        mac_last = 1'b0, mac_valid = 1'b0;
  logic [7:0]  o_recv_data, o_recv_type;
  logic [15:0] o_recv_len;
  logic [31:0] o_recv_src_ip;
  logic        o_recv_last, o_recv_valid, o_drop;
  typedef struct {logic [7:0] d; logic l; int c;} ev_t;
  ev_t         obs[$], exp_q[$];
  logic [7:0]  frm[$];
  int          in_cyc[0:2047];
  int          cyc = 0, drops = 0, exp_drops = 0, n_tests = 0, n_fail = 0;
  logic [31:0] model_ip = DEF_IP, m_src = '0;
  logic [15:0] m_len = '0;
  logic [7:0]  m_type = '0;

  ip_rx dut (
    .i_clk(clk), .i_rst(rst), .i_local_ip(lip), .i_local_ip_valid(lip_valid),
    .i_mac_data(mac_data), .i_mac_type(mac_type), .i_mac_last(mac_last), .i_mac_valid(mac_valid),
    .o_recv_data(o_recv_data), .o_recv_type(o_recv_type), .o_recv_len(o_recv_len),
    .o_recv_src_ip(o_recv_src_ip), .o_recv_last(o_recv_last), .o_recv_valid(o_recv_valid),
    .o_drop(o_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) begin
    if (o_recv_valid) obs.push_back('{o_recv_data, o_recv_last, cyc});
    if (o_drop) drops++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mac_valid = 1'b0; mac_last = 1'b0; lip_valid = 1'b0;
    end
  endtask

  task automatic build(input logic [7:0] v, input logic [7:0] proto, input logic [31:0] src,
                       input logic [31:0] dst, input int tl, input int n, input bit bad_cs, input bit seq);
    logic [7:0]  h[20];
    logic [31:0] s;
    h[0] = v; h[1] = 8'h00; h[2] = 8'(tl >> 8); h[3] = 8'(tl);
    h[4] = 8'($urandom); h[5] = 8'($urandom); h[6] = 8'h00; h[7] = 8'h00;
    h[8] = 8'd64; h[9] = proto; h[10] = 8'h00; h[11] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      h[12 + k] = src[31 - 8 * k -: 8];
      h[16 + k] = dst[31 - 8 * k -: 8];
    end
    s = 0;
    for (int k = 0; k < 10; k++) s += {16'd0, h[2 * k], h[2 * k + 1]};
    while (s > 32'hFFFF) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    h[10] = ~s[15:8];
    h[11] = bad_cs ? s[7:0] : ~s[7:0];
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(i < 20 ? h[i] : (seq ? 8'(i - 19) : 8'($urandom)));
  endtask

  // Expected behaviour of one received frame, derived from the bytes actually sent.
  task automatic model(input logic [15:0] typ, input logic [31:0] ip);
    int          n, tl, stop;
    logic [31:0] s, dst;
    bit          ok;
    n = frm.size();
    if (typ != 16'h0800) return;
    if (n <= 20) begin exp_drops++; return; end
    tl = {frm[2], frm[3]};
    s = 0;
    for (int k = 0; k < 10; k++) s += {16'd0, frm[2 * k], frm[2 * k + 1]};
    while (s > 32'hFFFF) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    dst = {frm[16], frm[17], frm[18], frm[19]};
    ok = frm[0] == 8'h45 && s == 32'hFFFF && (dst == ip || dst == 32'hFFFFFFFF) &&
         (frm[9] == 8'd1 || frm[9] == 8'd17) && tl >= 21 && tl <= 1500;
    if (!ok) begin exp_drops++; return; end
    m_type = frm[9];
    m_len  = 16'(tl - 20);
    m_src  = {frm[12], frm[13], frm[14], frm[15]};
    stop = n < tl ? n : tl;
    for (int i = 20; i < stop; i++) exp_q.push_back('{frm[i], i == stop - 1, in_cyc[i] + 1});
    if (n < tl) exp_drops++;
  endtask

  task automatic send(input logic [15:0] typ, input int upd_at, input logic [31:0] upd_ip);
    logic [31:0] ip0;
    ip0 = model_ip;
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      mac_valid = 1'b1; mac_data = frm[i]; mac_type = typ; mac_last = (i == frm.size() - 1);
      lip_valid = (i == upd_at); lip = upd_ip;
      in_cyc[i] = cyc;
    end
    if (upd_at >= 0) model_ip = upd_ip;
    model(typ, ip0);
  endtask

  task automatic checkpoint(input string tag);
    idle(4);
    check({tag, " count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      check({tag, " data"}, {24'd0, obs[i].d}, {24'd0, exp_q[i].d});
      check({tag, " last"}, {31'd0, obs[i].l}, {31'd0, exp_q[i].l});
      check({tag, " cycle"}, obs[i].c, exp_q[i].c);
    end
    check({tag, " drops"}, drops, exp_drops);
    check({tag, " type"}, {24'd0, o_recv_type}, {24'd0, m_type});
    check({tag, " len"}, {16'd0, o_recv_len}, {16'd0, m_len});
    check({tag, " src"}, o_recv_src_ip, m_src);
    obs.delete(); exp_q.delete(); drops = 0; exp_drops = 0;
  endtask

  initial begin
    logic [15:0] typ;
    logic [7:0]  proto;
    logic [31:0] dst;
    int          tl, n, base;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", {31'd0, o_recv_valid}, 0);
    check("reset data", {24'd0, o_recv_data}, 0);
    check("reset last", {31'd0, o_recv_last}, 0);
    check("reset drop", {31'd0, o_drop}, 0);
    @(negedge clk) rst = 1'b0;
    idle(2);
    checkpoint("reset");

    build(8'h45, 8'd17, 32'h0A010203, DEF_IP, 28, 28, 0, 1); send(16'h0800, -1, 0); checkpoint("udp");
    check("udp len8", {16'd0, o_recv_len}, 8);
    check("udp type17", {24'd0, o_recv_type}, 17);
    build(8'h45, 8'd17, 32'h0A010203, DEF_IP, 28, 28, 1, 1); send(16'h0800, -1, 0); checkpoint("bad csum");
    build(8'h45, 8'd17, 32'h0A010204, 32'hC0A80107, 28, 28, 0, 1); send(16'h0800, -1, 0); checkpoint("dst other");
    build(8'h45, 8'd1, 32'h0A010205, 32'hFFFFFFFF, 28, 28, 0, 0); send(16'h0800, -1, 0); checkpoint("bcast");
    build(8'h45, 8'd17, 32'h0A010206, DEF_IP, 28, 46, 0, 1); send(16'h0800, -1, 0); checkpoint("padding");
    build(8'h45, 8'd17, 32'h0A010207, DEF_IP, 28, 28, 0, 0); send(16'h0806, -1, 0);
    build(8'h45, 8'd17, 32'h0A010208, DEF_IP, 28, 28, 0, 1); send(16'h0800, -1, 0); checkpoint("arp b2b");
    build(8'h45, 8'd17, 32'h0A010209, DEF_IP, 21, 21, 0, 0); send(16'h0800, -1, 0); checkpoint("len21");
    build(8'h45, 8'd17, 32'h0A01020A, DEF_IP, 1500, 30, 0, 0); send(16'h0800, -1, 0); checkpoint("len1500 trunc");
    build(8'h45, 8'd17, 32'h0A01020B, DEF_IP, 1501, 30, 0, 0); send(16'h0800, -1, 0); checkpoint("len1501");
    build(8'h45, 8'd17, 32'h0A01020C, DEF_IP, 28, 12, 0, 0); send(16'h0800, -1, 0); checkpoint("runt");
    build(8'h45, 8'd17, 32'h0A01020D, DEF_IP, 30, 30, 0, 0); send(16'h0800, 5, 32'h0A000005); checkpoint("ip upd old");
    build(8'h45, 8'd17, 32'h0A01020E, 32'h0A000005, 30, 30, 0, 0); send(16'h0800, -1, 0); checkpoint("ip upd new");
    build(8'h45, 8'd17, 32'h0A01020F, DEF_IP, 30, 30, 0, 0); send(16'h0800, -1, 0); checkpoint("ip upd stale");

    for (int t = 0; t < 60; t++) begin
      typ = ($urandom % 8 == 0) ? 16'h86DD : 16'h0800;
      case ($urandom % 3)
        0: proto = 8'd1;
        1: proto = 8'd17;
        default: proto = 8'd6;
      endcase
      case ($urandom % 4)
        0: dst = 32'hFFFFFFFF;
        1: dst = $urandom;
        default: dst = model_ip;
      endcase
      tl = ($urandom % 10 == 0) ? (($urandom % 2 == 0) ? 20 : 1501 + int'($urandom % 100)) : 21 + int'($urandom % 40);
      base = tl > 100 ? 40 : tl;
      case ($urandom % 6)
        0: n = base + int'($urandom % 20);
        1: n = 1 + int'($urandom % 20);
        2: n = base > 21 ? 21 + int'($urandom % (base - 21)) : base;
        default: n = base;
      endcase
      build(($urandom % 10 == 0) ? 8'h46 : 8'h45, proto, $urandom, dst, tl, n, $urandom % 8 == 0, 0);
      send(typ, -1, 0);
      if ($urandom % 3 != 0) checkpoint("rand");
    end
    checkpoint("rand end");

    build(8'h45, 8'd17, 32'h0A010210, model_ip, 40, 40, 0, 1);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      mac_valid = 1'b1; mac_data = frm[i]; mac_type = 16'h0800; mac_last = 1'b0;
    end
    #5;
    check("rst pre count", obs.size(), 3);
    rst = 1'b1;
    #1;
    check("rst valid", {31'd0, o_recv_valid}, 0);
    check("rst data", {24'd0, o_recv_data}, 0);
    check("rst len", {16'd0, o_recv_len}, 0);
    check("rst src", o_recv_src_ip, 0);
    check("rst type", {24'd0, o_recv_type}, 0);
    obs.delete(); exp_q.delete(); drops = 0; exp_drops = 0;
    model_ip = DEF_IP; m_type = '0; m_len = '0; m_src = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 24; i < 40; i++) begin
      @(posedge clk); #1;
      mac_data = frm[i]; mac_last = (i == 39);
    end
    checkpoint("rst tail");
    build(8'h45, 8'd17, 32'h0A010211, DEF_IP, 28, 28, 0, 1); send(16'h0800, -1, 0); checkpoint("post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ip_rx.md
IP_RX -- requirements
Module: ip_rx

Interface
REQ-001 Parameter P_LOCAL_IP, default {8'd192,8'd168,8'd1,8'd1}, reset value of the local IPv4 address.
REQ-002 i_clk  in  1  clock; all logic rising-edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_local_ip / i_local_ip_valid  in  32/1  runtime local-IP update; loaded on the cycle valid=1.
REQ-005 i_mac_data  in  8  received Ethernet payload byte, MSB-first network order.
REQ-006 i_mac_type  in  16  EtherType of the current frame, stable while i_mac_valid=1.
REQ-007 i_mac_last / i_mac_valid  in  1/1  last-byte marker / byte strobe; valid is contiguous within a frame.
REQ-008 o_recv_data  out  8  IP payload byte.
REQ-009 o_recv_type  out  8  IP protocol field (17 UDP, 1 ICMP).
REQ-010 o_recv_len  out  16  payload length = total length - 20.
REQ-011 o_recv_src_ip  out  32  source IP of the accepted packet.
REQ-012 o_recv_last / o_recv_valid  out  1/1  last-payload-byte marker / byte strobe.
REQ-013 o_drop  out  1  one-cycle pulse when a packet is discarded.

Function
REQ-014 States: IDLE, HDR, PAYLOAD, DISCARD; one 16-bit byte counter cnt counts bytes of the current frame from 0.
REQ-015 IDLE -> HDR on i_mac_valid with i_mac_type==16'h0800 (that byte is cnt 0); other types -> DISCARD.
REQ-016 HDR captures bytes 0..19: byte0 must be 8'h45, bytes 2-3 total length, byte 9 protocol, bytes 12-15 source IP, bytes 16-19 destination IP.
REQ-017 Header checksum: 32-bit accumulate of the ten 16-bit header words (including received checksum field), fold carries twice; pass iff result == 16'hFFFF.
REQ-018 Accept at cnt 19 iff: byte0==8'h45, destination IP == local IP or 32'hFFFFFFFF, protocol in {1,17}, checksum passes, total length in 21..1500.
REQ-019 Accepted: HDR -> PAYLOAD; o_recv_type, o_recv_len, o_recv_src_ip update on the cycle after cnt 19 and stay stable until the next accepted packet.
REQ-020 Rejected: HDR -> DISCARD, o_drop pulses once the cycle after cnt 19; no payload output.
REQ-021 PAYLOAD: each input byte with cnt in 20..total_len-1 appears on o_recv_data/o_recv_valid exactly 1 cycle later; no bubbles inserted, none removed.
REQ-022 o_recv_last asserts with payload byte at cnt == total_len-1; bytes beyond total length (Ethernet padding) are not output.
REQ-023 i_mac_last during HDR (runt frame): drop, o_drop pulse, -> IDLE.
REQ-024 i_mac_last in PAYLOAD before cnt==total_len-1 (truncated): that byte output with o_recv_last=1 and o_drop pulses same cycle.
REQ-025 DISCARD and post-length PAYLOAD consume bytes silently until i_mac_last, then -> IDLE.
REQ-026 Any state: i_mac_valid with i_mac_last -> IDLE next cycle; a new frame may start the very next cycle.
REQ-027 i_local_ip_valid mid-packet takes effect for the next packet only (compare uses a copy latched at cnt 0).
REQ-028 cnt saturates at 16'hFFFF; no wrap.

Reset
REQ-029 On i_rst: state IDLE, cnt 0, local IP = P_LOCAL_IP, all outputs 0.
REQ-030 Reset mid-frame: remaining bytes of that frame are parsed as a new frame from IDLE only if i_mac_valid was low for at least one cycle after reset release; otherwise they go to DISCARD.

Verification
REQ-031 UDP packet, dst 192.168.1.1, total len 28, valid checksum, 8 payload bytes 01..08 -> 8 o_recv_valid cycles, data 01..08, o_recv_len 8, o_recv_type 17, last on 08, latency 1.
REQ-032 Same packet with checksum byte 11 flipped -> no o_recv_valid, one o_drop pulse.
REQ-033 Dst 192.168.1.7 -> dropped; dst 255.255.255.255 -> accepted.
REQ-034 46-byte frame carrying total len 28 (18 padding bytes) -> exactly 8 payload bytes, last on 8th, padding suppressed.
REQ-035 Frame with EtherType 16'h0806 then back-to-back valid IPv4 frame -> first ignored without o_drop, second fully delivered.
REQ-036 i_rst asserted at payload byte 3 -> outputs 0 immediately; next clean frame delivered correctly.
